// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I/RV64I opcodes, immediate formats and the
// immediate generator. Used by decode_stage; the optional write-back bypass is
// controlled by the DECODE_WB_BYPASS_EN macro in decode_stage.sv.
package decode_pkg;

  // Widest supported datapath; imm_gen sign-extends to this width and the
  // caller truncates to its own XLEN (truncating a sign extension is still a
  // correct sign extension).
  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  // Immediate format selected purely by opcode; unknown opcodes give no immediate.
  function automatic imm_fmt_t imm_fmt(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: fmt = IMM_I;
      OP_STORE:                 fmt = IMM_S;
      OP_BRANCH:                fmt = IMM_B;
      OP_LUI, OP_AUIPC:         fmt = IMM_U;
      OP_JAL:                   fmt = IMM_J;
      default:                  fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // Sign-extended immediate (sign bit is always instr[31]).
  function automatic logic [MAX_XLEN-1:0] imm_gen(input logic [31:0] instr);
    logic [MAX_XLEN-1:0] imm;
    case (imm_fmt(instr[6:0]))
      IMM_I: imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {{32{instr[31]}}, instr[31:12], 12'h000};
      IMM_J: imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // rs1 is a real source for everything except LUI, AUIPC and JAL.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  // rs2 is a real source only for R, S and B formats.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/decode_reg_file_mp.sv
// Integer register file: two combinational read ports, one write port,
// synchronous active-high reset to REG_RESET_VAL, x0 reads as zero and
// ignores writes.
module reg_file_mp #(
  parameter int              XLEN          = 32,
  parameter int              NUM_REGS      = 32,
  parameter logic [XLEN-1:0] REG_RESET_VAL = '0,
  localparam int             AW            = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  // Register storage: reset all entries, otherwise a single write per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= REG_RESET_VAL;
      end
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational reads; x0 is forced to zero regardless of its storage.
  always_comb begin
    rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage between the fetch buffer and EX.
// Holds the register file and immediate generator, detects load-use hazards,
// supports flush, and presents a valid/ready output register to EX.
// Optional feature macro: DECODE_WB_BYPASS_EN (write-back forwarding into the
// captured operands and into a held output bundle).
//
// Handshake: the input is taken when in_valid && in_ready; the output bundle
// transfers when out_valid && out_ready. While out_valid && !out_ready every
// out_* field is held. flush kills both the held bundle and the incoming
// instruction and always reports in_ready=1.
module decode_stage import decode_pkg::*; #(
  parameter int              XLEN          = 32,
  parameter int              NUM_REGS      = 32,
  parameter logic [XLEN-1:0] REG_RESET_VAL = '0,
  localparam int             AW            = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_is_load,
  input  logic [AW-1:0]   ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rs1,
  output logic [AW-1:0]   out_rs2,
  output logic [AW-1:0]   out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7
);

  logic [6:0]      opcode;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rf_rs1, rf_rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm;
  logic            lu, adv;

  logic            out_valid_q,    out_valid_d;
  logic [XLEN-1:0] out_pc_q,       out_pc_d;
  logic [XLEN-1:0] out_rs1_data_q, out_rs1_data_d;
  logic [XLEN-1:0] out_rs2_data_q, out_rs2_data_d;
  logic [XLEN-1:0] out_imm_q,      out_imm_d;
  logic [AW-1:0]   out_rs1_q,      out_rs1_d;
  logic [AW-1:0]   out_rs2_q,      out_rs2_d;
  logic [AW-1:0]   out_rd_q,       out_rd_d;
  logic [6:0]      out_opcode_q,   out_opcode_d;
  logic [2:0]      out_funct3_q,   out_funct3_d;
  logic [6:0]      out_funct7_q,   out_funct7_d;

  assign opcode = instr_in[6:0];
  assign rs1    = AW'(instr_in[19:15]);
  assign rs2    = AW'(instr_in[24:20]);
  assign rd     = AW'(instr_in[11:7]);
  assign imm    = XLEN'(imm_gen(instr_in));

  reg_file_mp #(
    .XLEN          (XLEN),
    .NUM_REGS      (NUM_REGS),
    .REG_RESET_VAL (REG_RESET_VAL)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs1),
    .rdata1_o (rf_rs1),
    .raddr2_i (rs2),
    .rdata2_o (rf_rs2),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data)
  );

`ifdef DECODE_WB_BYPASS_EN
  // Same-cycle write-back wins over the (not yet updated) register file.
  assign rs1_val = (wb_en && rs1 != '0 && wb_addr == rs1) ? wb_data : rf_rs1;
  assign rs2_val = (wb_en && rs2 != '0 && wb_addr == rs2) ? wb_data : rf_rs2;
`else
  // Without bypass the captured operand is the pre-write register value.
  assign rs1_val = rf_rs1;
  assign rs2_val = rf_rs2;
`endif

  // Hazard and handshake: stall only when EX holds a load feeding a real source.
  always_comb begin
    adv      = !out_valid_q || out_ready;
    lu       = in_valid && ex_is_load && (ex_rd != '0) &&
               ((uses_rs1(opcode) && ex_rd == rs1) ||
                (uses_rs2(opcode) && ex_rd == rs2));
    in_ready = (adv && !lu) || flush;
  end

  // Output register next state: load on advance, drop on flush, else hold.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_imm_d      = out_imm_q;
    out_rs1_d      = out_rs1_q;
    out_rs2_d      = out_rs2_q;
    out_rd_d       = out_rd_q;
    out_opcode_d   = out_opcode_q;
    out_funct3_d   = out_funct3_q;
    out_funct7_d   = out_funct7_q;
    if (adv) begin
      // A stalled or flushed input still loads the fields but is marked a bubble.
      out_valid_d    = in_valid && !lu && !flush;
      out_pc_d       = pc_in;
      out_rs1_data_d = rs1_val;
      out_rs2_data_d = rs2_val;
      out_imm_d      = imm;
      out_rs1_d      = rs1;
      out_rs2_d      = rs2;
      out_rd_d       = rd;
      out_opcode_d   = opcode;
      out_funct3_d   = instr_in[14:12];
      out_funct7_d   = instr_in[31:25];
    end else if (flush) begin
      out_valid_d = 1'b0;
    end else begin
`ifdef DECODE_WB_BYPASS_EN
      // Keep a held bundle coherent with write-backs that land while EX waits.
      if (wb_en && out_rs1_q != '0 && wb_addr == out_rs1_q) out_rs1_data_d = wb_data;
      if (wb_en && out_rs2_q != '0 && wb_addr == out_rs2_q) out_rs2_data_d = wb_data;
`endif
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_imm_q      <= '0;
      out_rs1_q      <= '0;
      out_rs2_q      <= '0;
      out_rd_q       <= '0;
      out_opcode_q   <= '0;
      out_funct3_q   <= '0;
      out_funct7_q   <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_imm_q      <= out_imm_d;
      out_rs1_q      <= out_rs1_d;
      out_rs2_q      <= out_rs2_d;
      out_rd_q       <= out_rd_d;
      out_opcode_q   <= out_opcode_d;
      out_funct3_q   <= out_funct3_d;
      out_funct7_q   <= out_funct7_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
  assign out_imm      = out_imm_q;
  assign out_rs1      = out_rs1_q;
  assign out_rs2      = out_rs2_q;
  assign out_rd       = out_rd_q;
  assign out_opcode   = out_opcode_q;
  assign out_funct3   = out_funct3_q;
  assign out_funct7   = out_funct7_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage (XLEN=32, NUM_REGS=32, REG_RESET_VAL=0). Honours
// DECODE_WB_BYPASS_EN in its reference model. Directed scenarios first, then
// randomised traffic, all checked through one scoreboard.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int EW   = 4 * XLEN + 32;

  logic            clk, rst;
  logic            in_valid, in_ready;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush, ex_is_load;
  logic [AW-1:0]   ex_rd;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [AW-1:0]   out_rs1, out_rs2, out_rd;
  logic [6:0]      out_opcode, out_funct7;
  logic [2:0]      out_funct3;

  decode_stage #(.XLEN(XLEN), .NUM_REGS(32), .REG_RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0]   exp_q[$];
  logic [XLEN-1:0] mregs [32];

  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] i);
    logic signed [63:0] v;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: v = $signed(i[31:20]);
      7'h23:               v = $signed({i[31:25], i[11:7]});
      7'h63:               v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      7'h37, 7'h17:        v = $signed({i[31:12], 12'h000});
      7'h6F:               v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      default:             v = 64'sd0;
    endcase
    return v[XLEN-1:0];
  endfunction

  function automatic logic src1(input logic [6:0] op);
    return (op != 7'h37) && (op != 7'h17) && (op != 7'h6F);
  endfunction

  function automatic logic src2(input logic [6:0] op);
    return (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
  endfunction

  logic            m_valid, m_lu, m_adv;
  logic [EW-1:0]   e;
  logic [31:0]     e_instr;
  logic [XLEN-1:0] r1v, r2v;

  // Scoreboard: compare what EX takes, then record what the stage captures.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) mregs[i] = '0;
    end else begin
      m_valid = (exp_q.size() != 0);
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      m_lu  = in_valid && ex_is_load && ex_rd != 0 &&
              ((src1(instr_in[6:0]) && ex_rd == instr_in[19:15]) ||
               (src2(instr_in[6:0]) && ex_rd == instr_in[24:20]));
      m_adv = !m_valid || out_ready;
      check("in_ready", {63'd0, in_ready}, {63'd0, (m_adv && !m_lu) || flush});
      if (m_valid) begin
        if (out_ready) begin
          e = exp_q.pop_front();
          e_instr = e[31:0];
          check("pc",       64'(out_pc),       64'(e[4*XLEN+31:3*XLEN+32]));
          check("rs1_data", 64'(out_rs1_data), 64'(e[3*XLEN+31:2*XLEN+32]));
          check("rs2_data", 64'(out_rs2_data), 64'(e[2*XLEN+31:XLEN+32]));
          check("imm",      64'(out_imm),      64'(e[XLEN+31:32]));
          check("rs1",      64'(out_rs1),      64'(e_instr[19:15]));
          check("rs2",      64'(out_rs2),      64'(e_instr[24:20]));
          check("rd",       64'(out_rd),       64'(e_instr[11:7]));
          check("opcode",   64'(out_opcode),   64'(e_instr[6:0]));
          check("funct3",   64'(out_funct3),   64'(e_instr[14:12]));
          check("funct7",   64'(out_funct7),   64'(e_instr[31:25]));
        end else if (flush) begin
          void'(exp_q.pop_front());
        end else begin
`ifdef DECODE_WB_BYPASS_EN
          e = exp_q[0];
          if (wb_en && wb_addr != 0 && wb_addr == e[19:15]) e[3*XLEN+31:2*XLEN+32] = wb_data;
          if (wb_en && wb_addr != 0 && wb_addr == e[24:20]) e[2*XLEN+31:XLEN+32]   = wb_data;
          exp_q[0] = e;
`endif
        end
      end
      if (in_valid && m_adv && !m_lu && !flush) begin
        r1v = mregs[instr_in[19:15]];
        r2v = mregs[instr_in[24:20]];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr != 0 && wb_addr == instr_in[19:15]) r1v = wb_data;
        if (wb_en && wb_addr != 0 && wb_addr == instr_in[24:20]) r2v = wb_data;
`endif
        exp_q.push_back({pc_in, r1v, r2v, ref_imm(instr_in), instr_in});
      end
      if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; instr_in = '0; pc_in = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    flush = 0; ex_is_load = 0; ex_rd = '0; out_ready = 1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    in_valid = 1; instr_in = ins; pc_in = pc;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic rand_cycle();
    logic [31:0] ins;
    logic [6:0]  op;
    case ($urandom_range(0, 10))
      0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h23;  3: op = 7'h63;
      4: op = 7'h6F;  5: op = 7'h67;  6: op = 7'h37;  7: op = 7'h17;
      8: op = 7'h33;  9: op = 7'h73;  default: op = 7'h7F;
    endcase
    ins = $urandom;
    ins[6:0]   = op;
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    in_valid   = ($urandom_range(0, 9) < 8);
    instr_in   = ins;
    pc_in      = XLEN'($urandom);
    wb_en      = ($urandom_range(0, 1) == 1);
    wb_addr    = 5'($urandom_range(0, 7));
    wb_data    = XLEN'($urandom);
    ex_is_load = ($urandom_range(0, 3) == 0);
    ex_rd      = 5'($urandom_range(0, 7));
    flush      = ($urandom_range(0, 19) == 0);
    out_ready  = ($urandom_range(0, 9) < 7);
  endtask

  localparam logic [31:0] ADD_X7   = 32'h000283B3; // add  x7, x5, x0
  localparam logic [31:0] BEQ_M8   = 32'hFE000CE3; // beq  x0, x0, -8
  localparam logic [31:0] ADDI_X9  = 32'h00128493; // addi x9, x5, 1
  localparam logic [31:0] LUI_X10  = 32'h00028537; // lui  x10, 0x28 (rs1 field = 5)
  localparam logic [31:0] ADD_X11  = 32'h000005B3; // add  x11, x0, x0
  localparam logic [31:0] ADD_X12  = 32'h00728633; // add  x12, x5, x7
  localparam logic [XLEN-1:0] NEG8 = {{(XLEN-4){1'b1}}, 4'h8};
`ifdef DECODE_WB_BYPASS_EN
  localparam logic [XLEN-1:0] HELD_R1 = 32'h55;
`else
  localparam logic [XLEN-1:0] HELD_R1 = 32'hAA;
`endif

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    check("rst_pc",  64'(out_pc), 0);
    check("rst_imm", 64'(out_imm), 0);
    check("rst_rs1_data", 64'(out_rs1_data), 0);
    check("rst_rd",  64'(out_rd), 0);
    cyc();

    // x5 = 0xAA then add x7, x5, x0
    wb(5, 32'hAA); cyc(); wb_en = 0;
    send(ADD_X7, 32'h100); cyc(); in_valid = 0;
    @(negedge clk);
    check("add_valid", {63'd0, out_valid}, 1);
    check("add_rs1_data", 64'(out_rs1_data), 64'h0AA);
    check("add_rs2_data", 64'(out_rs2_data), 0);
    check("add_rd", 64'(out_rd), 7);
    cyc();

    // branch immediate -8
    send(BEQ_M8, 32'h104); cyc(); in_valid = 0;
    @(negedge clk);
    check("beq_imm", 64'(out_imm), 64'(NEG8));
    cyc();

    // load-use stall on rs1 = x5
    ex_is_load = 1; ex_rd = 5; send(ADDI_X9, 32'h108);
    @(negedge clk); check("lu_ready", {63'd0, in_ready}, 0); cyc();
    @(negedge clk); check("lu_bubble", {63'd0, out_valid}, 0); cyc();
    ex_is_load = 0;
    @(negedge clk); check("lu_release", {63'd0, in_ready}, 1); cyc();
    in_valid = 0;
    @(negedge clk);
    check("lu_valid", {63'd0, out_valid}, 1);
    check("lu_rs1_data", 64'(out_rs1_data), 64'h0AA);
    check("lu_imm", 64'(out_imm), 1);
    cyc();

    // rs1 of LUI and rs2 of an I-type are not sources
    ex_is_load = 1; ex_rd = 5; send(LUI_X10, 32'h10C);
    @(negedge clk); check("lui_no_stall", {63'd0, in_ready}, 1); cyc();
    ex_rd = 1; send(ADDI_X9, 32'h110);
    @(negedge clk); check("itype_no_stall", {63'd0, in_ready}, 1); cyc();
    ex_is_load = 0; in_valid = 0; cyc();

    // hold for three cycles with a write-back to x5 in the first
    send(ADD_X7, 32'h120); cyc();
    out_ready = 0; send(ADDI_X9, 32'h124); wb(5, 32'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready", {63'd0, in_ready}, 0);
      check("hold_pc", 64'(out_pc), 64'h120);
      check("hold_rd", 64'(out_rd), 7);
      check("hold_rs1_data", 64'(out_rs1_data), (i == 0) ? 64'h0AA : 64'(HELD_R1));
      cyc();
      wb_en = 0;
    end
    out_ready = 1;
    @(negedge clk); check("hold_release", {63'd0, in_ready}, 1); cyc();
    in_valid = 0;
    @(negedge clk); check("after_hold_rs1", 64'(out_rs1_data), 64'h055); cyc();

    // flush during hold
    send(ADD_X7, 32'h130); cyc();
    out_ready = 0; flush = 1; send(ADDI_X9, 32'h134);
    @(negedge clk); check("flush_hold_ready", {63'd0, in_ready}, 1); cyc();
    flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk); check("flush_hold_valid", {63'd0, out_valid}, 0); cyc();

    // flush during stall
    ex_is_load = 1; ex_rd = 5; send(ADDI_X9, 32'h138); flush = 1;
    @(negedge clk); check("flush_stall_ready", {63'd0, in_ready}, 1); cyc();
    flush = 0; in_valid = 0; ex_is_load = 0;
    @(negedge clk); check("flush_stall_valid", {63'd0, out_valid}, 0); cyc();

    // x0 ignores writes
    wb(0, 32'hDEAD); cyc(); wb_en = 0;
    send(ADD_X11, 32'h140); cyc(); in_valid = 0;
    @(negedge clk); check("x0_read", 64'(out_rs1_data), 0); cyc();

    // reset while holding
    send(ADD_X7, 32'h150); cyc();
    out_ready = 0; in_valid = 0; cyc();
    rst = 1; cyc(); rst = 0; out_ready = 1;
    @(negedge clk); check("rst_hold_valid", {63'd0, out_valid}, 0); cyc();
    send(ADD_X12, 32'h160); cyc(); in_valid = 0;
    @(negedge clk);
    check("rst_x5", 64'(out_rs1_data), 0);
    check("rst_x7", 64'(out_rs2_data), 0);
    cyc();

    // randomised traffic
    repeat (400) begin
      rand_cycle();
      cyc();
    end
    idle();
    repeat (4) cyc();
    @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
